mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage with a single-port word memory and a fixed number of wait
// states per load/store. It stalls upstream while an access is pending and sends
// a bubble to MEM/WB during the stall.
module mem_access_stage #(
    parameter int MEMORY_DEPTH = 32,
    parameter int WAIT_STATES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic        reg_write_i,
    input  logic        mem_to_reg_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [4:0]  write_reg_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] read_data_2_i,
    input  logic [31:0] pc_plus_4_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic [4:0]  write_reg_o,
    output logic [31:0] read_data_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] pc_plus_4_o
);
    localparam int         AW       = $clog2(MEMORY_DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] pc_plus_4;
    } req_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    req_t        r_cap;
    req_t        w_in, w_sel;
    logic        w_req, w_stall, w_capture, w_commit, w_use_cap, w_mem_we;
    logic [AW-1:0] w_idx;
    logic [31:0] w_load_data;
    logic [31:0] r_mem [MEMORY_DEPTH];

    logic        r_valid, r_reg_write, r_mem_to_reg;
    logic [4:0]  r_write_reg;
    logic [31:0] r_read_data, r_alu_result, r_pc_plus_4;

    assign w_in = '{reg_write:  reg_write_i,
                    mem_to_reg: mem_to_reg_i,
                    mem_read:   mem_read_i,
                    mem_write:  mem_write_i,
                    write_reg:  write_reg_i,
                    alu_result: alu_result_i,
                    store_data: read_data_2_i,
                    pc_plus_4:  pc_plus_4_i};

    assign w_req = valid_i & (mem_read_i | mem_write_i) & ~flush_i;

    // Next-state, stall and completion decode for the IDLE/WAIT controller.
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        w_use_cap   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && (WAIT_STATES != 0)) begin
                    w_stall     = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = CNT_INIT;
                end else if (valid_i && !flush_i) begin
                    w_commit = 1'b1;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_commit    = 1'b1;
                    w_use_cap   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A pending access completes from the captured request; everything else
    // completes straight from the EX/MEM inputs.
    assign w_sel       = w_use_cap ? r_cap : w_in;
    assign w_idx       = w_sel.alu_result[AW+1:2];
    assign w_mem_we    = w_commit & w_sel.mem_write & reset;
    assign w_load_data = (w_sel.mem_read & ~w_sel.mem_write) ? r_mem[w_idx] : 32'd0;
    assign stall_o     = w_stall & reset;

    // Controller state, wait counter and the request captured on entering WAIT.
    // NOTE: sequential state uses non-blocking assignments only so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_cap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) r_cap <= w_in;
        end
    end

    // MEM/WB register: a completed instruction or a bubble every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_write_reg  <= 5'd0;
            r_read_data  <= 32'd0;
            r_alu_result <= 32'd0;
            r_pc_plus_4  <= 32'd0;
        end else if (w_commit) begin
            r_valid      <= 1'b1;
            r_reg_write  <= w_sel.reg_write;
            r_mem_to_reg <= w_sel.mem_to_reg;
            r_write_reg  <= w_sel.write_reg;
            r_read_data  <= w_load_data;
            r_alu_result <= w_sel.alu_result;
            r_pc_plus_4  <= w_sel.pc_plus_4;
        end else begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_write_reg  <= 5'd0;
            r_read_data  <= 32'd0;
            r_alu_result <= 32'd0;
            r_pc_plus_4  <= 32'd0;
        end
    end

    // Data memory write port, committed once at completion of a store.
    // NOTE: the array is deliberately outside the reset so contents survive a
    // reset and the memory can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_idx] <= w_sel.store_data;
    end

    assign valid_o      = r_valid;
    assign reg_write_o  = r_reg_write;
    assign mem_to_reg_o = r_mem_to_reg;
    assign write_reg_o  = r_write_reg;
    assign read_data_o  = r_read_data;
    assign alu_result_o = r_alu_result;
    assign pc_plus_4_o  = r_pc_plus_4;
endmodule
